ram_sample_logger_master: RTL and testbench
===========================================

# ram_sample_logger_master

Avalon-MM write master that streams 32-bit samples (phase currents, hall state, PWM duty snapshots) into the on-chip Nios II data RAM for later readout by software. It accepts samples on a valid/ready sink and issues single-word Avalon writes to a software-configured window of the RAM. The window is filled either once (one-shot) or continuously as a ring buffer. It sits in the Qsys system as an extra master on the RAM's s2 slave port, alongside the CPU on s1.

## Interface

Parameters:
- ADDR_W, 16: byte-address width of avm_address.
- LEN_W, 14: width of the word-count and pointer fields. 2^14 covers the full RAM depth.

Ports:
- clk, in, 1: single system clock; every register is clocked on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse; arms a capture. Ignored when busy=1 or cfg_len=0.
- stop, in, 1: one-cycle pulse; ends the capture early.
- cfg_base, in, ADDR_W: window base byte address. Bits [1:0] are ignored and treated as 0.
- cfg_len, in, LEN_W: window length in words, 1..2^LEN_W-1.
- cfg_circular, in, 1: 1 selects ring mode; 0 selects one-shot mode.
- snk_data, in, 32: sample word.
- snk_valid, in, 1: sample present.
- snk_ready, out, 1: logger can accept a sample.
- avm_address, out, ADDR_W: byte address of the current write.
- avm_write, out, 1: write request.
- avm_writedata, out, 32: write data.
- avm_byteenable, out, 4: constant 4'hF.
- avm_waitrequest, in, 1: slave/interconnect stall.
- busy, out, 1: capture in progress.
- done, out, 1: sticky; cleared by an accepted start.
- wrapped, out, 1: sticky; set on the first ring wrap, cleared by an accepted start.
- wr_ptr, out, LEN_W: word index of the next write within the window.

## Operation

- start, cfg_base, cfg_len and cfg_circular are sampled only on the cycle start is accepted. They are held internally for the whole capture.
- State IDLE: busy=0, snk_ready=0, avm_write=0.
  - An accepted start latches the config and sets wr_ptr=0, done=0, wrapped=0.
  - Next state: ARMED.
- State ARMED: busy=1, snk_ready=1.
  - snk_valid=1 captures snk_data into the holding register. Next state: WRITE.
  - stop=1 with snk_valid=0 sets done=1. Next state: IDLE.
  - stop=1 and snk_valid=1 on the same cycle: the sample is accepted, and stop is recorded as pending.
- State WRITE: busy=1, snk_ready=0, avm_write=1.
  - avm_address = base + (wr_ptr<<2), truncated to ADDR_W bits (modulo wrap).
  - avm_writedata = the holding register.
  - Address, data and write stay stable while avm_waitrequest=1. A write is never withdrawn except by reset.
  - The write completes on a cycle with avm_write=1 and avm_waitrequest=0. On completion:
    - Last word (wr_ptr == len-1), one-shot mode: done=1. Next state: IDLE.
    - Last word (wr_ptr == len-1), ring mode: wr_ptr=0, wrapped=1.
    - Otherwise: wr_ptr+1.
    - Then a pending stop gives done=1 and next state IDLE. With no pending stop, next state is ARMED.
  - A stop that arrives during WRITE is recorded as pending and takes effect only after the completion.
- start while busy=1 has no effect.
- In one-shot mode, done=1 is reached only after exactly cfg_len completed writes.
- Reset at any point returns to IDLE on the next edge. The in-flight write is abandoned and the pending stop is cleared.

## Timing

- Reset values: avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=4'hF, snk_ready=0, busy=0, done=0, wrapped=0, wr_ptr=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from snk_valid or avm_waitrequest to any output.
- start accepted at edge N: busy=1 and snk_ready=1 during cycle N+1.
- Sample accepted at edge N: avm_write=1 during cycle N+1.
- Completion at edge M (waitrequest=0): avm_write=0 and snk_ready=1 during cycle M+1 (ARMED), or busy=0 and done=1 (IDLE).
- Peak throughput is one word per 2 cycles with waitrequest held low.

## Test plan

- One-shot fill: base=0x0100, len=4, circular=0, valid held high, waitrequest=0.
  - Required: writes to 0x0100, 0x0104, 0x0108, 0x010C with data in order.
  - Required: done=1 two cycles after the 4th sample is accepted; busy=0; wr_ptr=0; exactly 4 write completions.
- Waitrequest stall: waitrequest held 1 for 5 cycles on the 2nd write.
  - Required: address 0x0104 and its data stable all 6 cycles; snk_ready=0 throughout; no sample lost or duplicated.
- Ring wrap: len=3, circular=1, 7 samples D0..D6.
  - Required: addresses cycle base+0, +4, +8, +0, ...
  - Required: wrapped=1 after the 3rd completion; final wr_ptr=1; done=0, busy=1.
- Stop handling:
  - stop during WRITE under waitrequest: the write completes, then done=1 and busy=0.
  - stop in ARMED: IDLE next cycle, with no write issued.
- Ignored starts:
  - start with cfg_len=0: busy stays 0.
  - start while busy, with a different cfg_base: addresses keep following the original base.
- Reset mid-write: reset asserted while avm_write=1 and waitrequest=1.
  - Required: next cycle all outputs at reset values.
  - Required: a fresh start then begins at wr_ptr=0.

Source files
------------

// File: rtl/ram_sample_logger_master.sv
// Avalon-MM write master that streams 32-bit samples from a valid/ready sink
// into a software-configured word window of on-chip RAM, either once
// (one-shot) or continuously as a ring buffer.
module ram_sample_logger_master #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_circular,
    input  logic [31:0]       snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [LEN_W-1:0]  wr_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_WRITE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic              circ_q;
    logic              stop_pend;

    logic              last_word;
    logic [LEN_W-1:0]  ptr_next;
    logic [ADDR_W-1:0] write_addr;

    // Full words only; the RAM slave ignores byte lanes otherwise.
    assign avm_byteenable = 4'hF;

    // Window bookkeeping derived from the latched config and current pointer.
    always_comb begin
        last_word  = (wr_ptr == (len_q - LEN_W'(1)));
        ptr_next   = last_word ? '0 : (wr_ptr + LEN_W'(1));
        write_addr = base_q + (ADDR_W'(wr_ptr) << 2);
    end

    // Capture FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            circ_q        <= 1'b0;
            stop_pend     <= 1'b0;
            snk_ready     <= 1'b0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wrapped       <= 1'b0;
            wr_ptr        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (cfg_len != '0)) begin
                        base_q    <= cfg_base & ~ADDR_W'(3);
                        len_q     <= cfg_len;
                        circ_q    <= cfg_circular;
                        stop_pend <= 1'b0;
                        wr_ptr    <= '0;
                        done      <= 1'b0;
                        wrapped   <= 1'b0;
                        busy      <= 1'b1;
                        snk_ready <= 1'b1;
                        state     <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (snk_valid) begin
                        // A stop arriving with the sample is deferred until
                        // that sample has been written.
                        avm_writedata <= snk_data;
                        avm_address   <= write_addr;
                        avm_write     <= 1'b1;
                        snk_ready     <= 1'b0;
                        stop_pend     <= stop;
                        state         <= ST_WRITE;
                    end else if (stop) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        snk_ready <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        wr_ptr    <= ptr_next;
                        if (last_word && circ_q) begin
                            wrapped <= 1'b1;
                        end
                        if ((last_word && !circ_q) || stop_pend || stop) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            snk_ready <= 1'b1;
                            state     <= ST_ARMED;
                        end
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sample_logger_master.sv
// Self-checking bench for ram_sample_logger_master: directed scenarios plus a
// randomized phase, all checked against a transaction-level window model.
module tb_ram_sample_logger_master;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              cfg_circular = 1'b0;
    logic [31:0]       snk_data = 32'h1000_0000;
    logic              snk_valid = 1'b0;
    logic              snk_ready;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest = 1'b0;
    logic              busy;
    logic              done;
    logic              wrapped;
    logic [LEN_W-1:0]  wr_ptr;

    int unsigned errors = 0;
    int unsigned checks = 0;

    ram_sample_logger_master #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .cfg_circular   (cfg_circular),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .wrapped        (wrapped),
        .wr_ptr         (wr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: capture window described as "active / one sample
    // in flight / next slot index", advanced once per clock from the inputs
    // that the coming rising edge will sample.
    bit          m_ok = 1'b0;
    bit          m_active = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_stop = 1'b0;
    bit          m_done = 1'b0;
    bit          m_wrapped = 1'b0;
    bit          m_circ = 1'b0;
    int unsigned m_base = 0;
    int unsigned m_len = 0;
    int unsigned m_ptr = 0;
    logic [31:0] m_hold = '0;
    int unsigned acc_cnt = 0;
    int unsigned comp_cnt = 0;
    bit          acc_next = 1'b0;
    logic [ADDR_W-1:0] addr_log[$];

    function automatic int unsigned slot_addr(int unsigned base, int unsigned idx);
        return (base + 4 * idx) % (1 << ADDR_W);
    endfunction

    always @(negedge clk) begin
        if (m_ok) begin
            check_eq("busy", busy, m_active);
            check_eq("snk_ready", snk_ready, m_active && !m_pend);
            check_eq("avm_write", avm_write, m_pend);
            check_eq("done", done, m_done);
            check_eq("wrapped", wrapped, m_wrapped);
            check_eq("wr_ptr", wr_ptr, m_ptr);
            check_eq("byteenable", avm_byteenable, 4'hF);
            if (m_pend) begin
                check_eq("avm_address", avm_address, slot_addr(m_base, m_ptr));
                check_eq("avm_writedata", avm_writedata, m_hold);
            end
        end
        acc_next = 1'b0;
        if (reset) begin
            m_ok = 1'b1;
            m_active = 1'b0;
            m_pend = 1'b0;
            m_stop = 1'b0;
            m_done = 1'b0;
            m_wrapped = 1'b0;
            m_ptr = 0;
        end else if (!m_active) begin
            if (start && cfg_len != 0) begin
                m_active = 1'b1;
                m_base = int'(cfg_base) & ~3;
                m_len = int'(cfg_len);
                m_circ = cfg_circular;
                m_ptr = 0;
                m_done = 1'b0;
                m_wrapped = 1'b0;
                m_stop = 1'b0;
            end
        end else if (!m_pend) begin
            if (snk_valid) begin
                m_pend = 1'b1;
                m_hold = snk_data;
                m_stop = stop;
                acc_next = 1'b1;
                acc_cnt++;
            end else if (stop) begin
                m_done = 1'b1;
                m_active = 1'b0;
            end
        end else if (!avm_waitrequest) begin
            comp_cnt++;
            addr_log.push_back(avm_address);
            m_pend = 1'b0;
            m_ptr++;
            if (m_ptr == m_len) begin
                m_ptr = 0;
                if (m_circ) m_wrapped = 1'b1;
                else begin
                    m_done = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (m_active && (m_stop || stop)) begin
                m_done = 1'b1;
                m_active = 1'b0;
            end
            m_stop = 1'b0;
        end else if (stop) begin
            m_stop = 1'b1;
        end
    end

    // Source: present a fresh sample once the previous one was taken.
    always @(posedge clk) begin
        if (acc_next) begin
            #1 snk_data = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base, input int unsigned len, input bit circ);
        cfg_base = base;
        cfg_len = LEN_W'(len);
        cfg_circular = circ;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (!busy) break;
            tick();
        end
        check_eq(tag, busy, 1'b0);
    endtask

    task automatic wait_write(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (avm_write) break;
            tick();
        end
        check_eq(tag, avm_write, 1'b1);
    endtask

    task automatic check_log(input int n, input int unsigned base, input int unsigned len, input string tag);
        check_eq({tag, "_count"}, addr_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < addr_log.size())
                check_eq(tag, addr_log[i], slot_addr(base, i % len));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_write"}, avm_write, 1'b0);
        check_eq({tag, "_addr"}, avm_address, '0);
        check_eq({tag, "_wdata"}, avm_writedata, '0);
        check_eq({tag, "_be"}, avm_byteenable, 4'hF);
        check_eq({tag, "_ready"}, snk_ready, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_wrapped"}, wrapped, 1'b0);
        check_eq({tag, "_wr_ptr"}, wr_ptr, '0);
    endtask

    initial begin
        int unsigned c0;
        int unsigned a0;
        logic [31:0] d;

        repeat (3) tick();
        reset = 1'b0;
        check_reset_values("rst");
        tick();

        // One-shot fill of four words at 0x0100.
        addr_log.delete();
        c0 = comp_cnt;
        do_start(16'h0100, 4, 1'b0);
        check_eq("os_start_busy", busy, 1'b1);
        check_eq("os_start_ready", snk_ready, 1'b1);
        snk_valid = 1'b1;
        tick();
        check_eq("os_first_write", avm_write, 1'b1);
        check_eq("os_first_ready", snk_ready, 1'b0);
        wait_idle(40, "os_timeout");
        check_eq("os_completions", comp_cnt - c0, 4);
        check_eq("os_done", done, 1'b1);
        check_eq("os_wr_ptr", wr_ptr, '0);
        check_log(4, 32'h0100, 4, "os_addr");
        snk_valid = 1'b0;
        tick();

        // Five-cycle waitrequest stall on the second write.
        addr_log.delete();
        c0 = comp_cnt;
        snk_valid = 1'b1;
        do_start(16'h0100, 4, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (avm_write && avm_address == 16'h0104) break;
            tick();
        end
        avm_waitrequest = 1'b1;
        d = avm_writedata;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) avm_waitrequest = 1'b0;
            check_eq("stall_addr", avm_address, 16'h0104);
            check_eq("stall_data", avm_writedata, d);
            check_eq("stall_write", avm_write, 1'b1);
            check_eq("stall_ready", snk_ready, 1'b0);
            tick();
        end
        wait_idle(40, "stall_timeout");
        check_eq("stall_completions", comp_cnt - c0, 4);
        check_log(4, 32'h0100, 4, "stall_addr_seq");
        snk_valid = 1'b0;
        tick();

        // Ring of three words fed seven samples.
        addr_log.delete();
        c0 = comp_cnt;
        do_start(16'h0200, 3, 1'b1);
        a0 = acc_cnt;
        snk_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (acc_cnt - a0 >= 7) break;
            tick();
        end
        snk_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (comp_cnt - c0 >= 7) break;
            tick();
        end
        check_eq("ring_completions", comp_cnt - c0, 7);
        check_eq("ring_wrapped", wrapped, 1'b1);
        check_eq("ring_wr_ptr", wr_ptr, 1);
        check_eq("ring_done", done, 1'b0);
        check_eq("ring_busy", busy, 1'b1);
        check_log(7, 32'h0200, 3, "ring_addr");

        // Stop while armed: idle next cycle, no write.
        c0 = comp_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_armed_busy", busy, 1'b0);
        check_eq("stop_armed_done", done, 1'b1);
        check_eq("stop_armed_write", avm_write, 1'b0);
        tick();
        check_eq("stop_armed_nowrite", comp_cnt - c0, 0);

        // Stop during a stalled write: the write still completes.
        do_start(16'h0100, 8, 1'b0);
        c0 = comp_cnt;
        snk_valid = 1'b1;
        wait_write(10, "stopw_write_seen");
        avm_waitrequest = 1'b1;
        snk_valid = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check_eq("stopw_held_write", avm_write, 1'b1);
        check_eq("stopw_held_busy", busy, 1'b1);
        avm_waitrequest = 1'b0;
        tick();
        check_eq("stopw_done", done, 1'b1);
        check_eq("stopw_busy", busy, 1'b0);
        check_eq("stopw_write", avm_write, 1'b0);
        check_eq("stopw_completions", comp_cnt - c0, 1);

        // Ignored starts: zero length, and a restart while busy.
        do_start(16'h0500, 0, 1'b0);
        check_eq("len0_busy", busy, 1'b0);
        addr_log.delete();
        c0 = comp_cnt;
        do_start(16'h0300, 4, 1'b0);
        do_start(16'h0800, 4, 1'b1);
        check_eq("restart_busy", busy, 1'b1);
        snk_valid = 1'b1;
        wait_idle(40, "restart_timeout");
        snk_valid = 1'b0;
        check_eq("restart_completions", comp_cnt - c0, 4);
        check_log(4, 32'h0300, 4, "restart_addr");
        check_eq("restart_done", done, 1'b1);

        // Reset while a write is stalled.
        do_start(16'h0100, 4, 1'b0);
        snk_valid = 1'b1;
        wait_write(10, "rstw_write_seen");
        avm_waitrequest = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_reset_values("rstw");
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        snk_valid = 1'b0;
        addr_log.delete();
        do_start(16'h0400, 2, 1'b0);
        check_eq("rstw_fresh_ptr", wr_ptr, '0);
        snk_valid = 1'b1;
        wait_idle(20, "rstw_timeout");
        snk_valid = 1'b0;
        check_log(2, 32'h0400, 2, "rstw_addr");

        // Randomized traffic, stalls, stops and (re)starts.
        for (int i = 0; i < 3000; i++) begin
            snk_valid = ($urandom_range(0, 3) != 0);
            avm_waitrequest = ($urandom_range(0, 2) == 0);
            stop = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 19) == 0);
            cfg_base = ADDR_W'($urandom);
            cfg_len = LEN_W'($urandom_range(0, 6));
            cfg_circular = $urandom_range(0, 1) != 0;
            tick();
        end
        start = 1'b0;
        snk_valid = 1'b0;
        avm_waitrequest = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(10, "rand_drain_timeout");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
